test_ram_master: RTL
====================

# test_ram_master

Initiator for the block-RAM test memory's request/ready handshake. Accepts a CPU-side transaction of one to three bytes: a read or a write at a base address. Issues one RAM handshake per byte at consecutive addresses and returns a little-endian assembled result. This is the 65c816 multi-byte operand fetch/store path: 8-bit, 16-bit and 24-bit accesses built from byte-wide RAM accesses.

## Interface
Parameters:
- ADDR_WIDTH, 16, RAM address width
- DATA_WIDTH, 8, RAM data width (one byte); the CPU-side data width is 3*DATA_WIDTH

Ports:
- clk  in  1  single clock; all state changes on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle request to begin a transaction; sampled only in IDLE
- wr  in  1  1 = write transaction, 0 = read; sampled with start
- len  in  2  byte count 1..3; value 0 is treated as 1
- base_addr  in  ADDR_WIDTH  address of byte 0
- wdata  in  3*DATA_WIDTH  write data; byte i is wdata[8i+7:8i]; sampled with start
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse; transaction complete
- rdata  out  3*DATA_WIDTH  read result; byte i from base_addr+i
- ram_req_rdwr  out  1  RAM request
- ram_we  out  1  RAM write enable
- ram_addr  out  ADDR_WIDTH  RAM address
- ram_data_in  out  DATA_WIDTH  RAM write data
- ram_data_out  in  DATA_WIDTH  RAM read data (registered in RAM)
- ram_data_ready  in  1  RAM ready

## Operation
- States: IDLE, REQ, GAP, DONE.
- IDLE behaviour:
  - start=1 latches wr, the effective len, base_addr and wdata, clears byte index i to 0 and moves to REQ.
  - On a read, rdata is cleared to 0 when start is accepted.
  - On a write, rdata holds its previous value.
- REQ behaviour:
  - ram_req_rdwr=1.
  - ram_addr = (base_addr + i) mod 2^ADDR_WIDTH; wraps at the top of memory.
  - ram_we = wr; ram_data_in = wdata byte i.
  - All RAM-side outputs are held stable until ram_data_ready=1 is sampled.
  - On ready: a read captures ram_data_out into rdata byte i. The block then moves to GAP with ram_req_rdwr and ram_we low at that same edge.
- GAP behaviour:
  - ram_req_rdwr=0 and ram_we=0.
  - The block stays in GAP while ram_data_ready=1, so a stale ready is never consumed.
  - When ram_data_ready=0 and i+1 < len, it increments i and goes to REQ.
  - When ram_data_ready=0 and i+1 = len, it goes to DONE.
- DONE behaviour: done=1 and busy=0 for one cycle, then IDLE.
- start outside IDLE is ignored; it is not queued.
- ram_data_ready while in IDLE or DONE is ignored.
- Reset (asynchronous, any state):
  - State goes to IDLE.
  - busy, done, ram_req_rdwr and ram_we all go to 0.
  - ram_addr, ram_data_in and rdata go to 0.
  - A write interrupted mid-byte may have already updated RAM. This is accepted and no rollback is done.
- Upper rdata bytes beyond len are 0 after a read.

## Timing
- Start accepted at edge N; REQ (ram_req_rdwr=1) is visible after edge N.
- The RAM raises ready 1 or 2 edges after the request, depending on its internal toggle phase. The block tolerates any latency ≥1 and waits indefinitely.
- Read data is captured on the same edge ram_data_ready is sampled high. ram_data_out at that edge is mem[ram_addr] as held during REQ.
- Per-byte cost is REQ (≥1 cycle) plus GAP (≥1 cycle). A len=3 transaction with 1-cycle ready takes 3×2 + 1 (DONE) = 7 cycles after start.
- busy is high from edge N through the last GAP cycle. It falls on the edge that asserts done.
- rdata is stable and valid from the cycle done is high until the next accepted read start.
- ram_we is never high while ram_req_rdwr is low.

## Test plan
- Single-byte read: preload mem[0x0010]=0xA5; start, wr=0, len=1, base_addr=0x0010 -> one RAM request at 0x0010, rdata=0x0000A5, one done pulse, busy low afterwards.
- Wrapping 24-bit read: mem[0xFFFE]=0x11, mem[0xFFFF]=0x22, mem[0x0000]=0x33; len=3, base_addr=0xFFFE -> ram_addr sequence FFFE, FFFF, 0000; rdata=0x332211; ram_req_rdwr low for ≥1 cycle between bytes.
- Write then readback: write len=2, base_addr=0x0100, wdata=0x00BEEF -> mem[0x0100]=0xEF, mem[0x0101]=0xBE. A following read with len=2 gives rdata=0x00BEEF; rdata unchanged during the write.
- Start while busy: pulse start again mid-read with base_addr=0x0200 -> ignored. Only the original addresses are accessed and exactly one done pulse occurs.
- len=0: read with base_addr=0x0010 -> behaves exactly as len=1; rdata=0x0000A5.
- Reset mid-transaction: deassert rst_n while in REQ of byte 1 of a len=3 read -> busy, done, ram_req_rdwr, ram_we and rdata are 0 immediately. After release the block sits in IDLE and a new len=1 read completes normally.

Source files
------------

// File: rtl/test_ram_master_if.sv
// Byte-wide request/ready bus between the test RAM master and the block-RAM test memory.
interface test_ram_master_if #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
);
   logic                  ram_req_rdwr;
   logic                  ram_we;
   logic [ADDR_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0] ram_data_in;
   logic [DATA_WIDTH-1:0] ram_data_out;
   logic                  ram_data_ready;

   modport master (
      output ram_req_rdwr, ram_we, ram_addr, ram_data_in,
      input  ram_data_out, ram_data_ready
   );

   modport slave (
      input  ram_req_rdwr, ram_we, ram_addr, ram_data_in,
      output ram_data_out, ram_data_ready
   );
endinterface

// File: rtl/test_ram_master.sv
// Splits a 1..3 byte CPU read/write into byte-wide RAM handshakes at consecutive
// addresses and assembles a little-endian result (65c816 multi-byte operand path).
module test_ram_master #(
   parameter int ADDR_WIDTH = 16,
   parameter int DATA_WIDTH = 8
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    wr,
   input  logic [1:0]              len,
   input  logic [ADDR_WIDTH-1:0]   base_addr,
   input  logic [3*DATA_WIDTH-1:0] wdata,
   output logic                    busy,
   output logic                    done,
   output logic [3*DATA_WIDTH-1:0] rdata,
   test_ram_master_if.master       ram
);

   typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

   state_t                  state;
   state_t                  state_next;
   logic                    wr_q;
   logic [1:0]              len_q;
   logic [1:0]              idx;
   logic [ADDR_WIDTH-1:0]   base_q;
   logic [3*DATA_WIDTH-1:0] wdata_q;
   logic                    last_byte;

   assign last_byte = ({1'b0, idx} + 3'd1) >= {1'b0, len_q};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // GAP waits for ready to drop so the previous byte's ready is never reused.
   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (start) state_next = REQ;
         REQ:  if (ram.ram_data_ready) state_next = GAP;
         GAP:  if (!ram.ram_data_ready) state_next = last_byte ? DONE : REQ;
         DONE: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_q    <= 1'b0;
         len_q   <= 2'd1;
         idx     <= 2'd0;
         base_q  <= '0;
         wdata_q <= '0;
         rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  wr_q    <= wr;
                  len_q   <= (len == 2'd0) ? 2'd1 : len;
                  base_q  <= base_addr;
                  wdata_q <= wdata;
                  idx     <= 2'd0;
                  if (!wr) rdata <= '0;
               end
            end
            REQ: begin
               if (ram.ram_data_ready && !wr_q)
                  rdata[idx*DATA_WIDTH +: DATA_WIDTH] <= ram.ram_data_out;
            end
            GAP: begin
               if (!ram.ram_data_ready && !last_byte) idx <= idx + 2'd1;
            end
            default: ;
         endcase
      end
   end

   // RAM-side outputs decode straight from registered state, so they hold steady through REQ.
   assign ram.ram_req_rdwr = (state == REQ);
   assign ram.ram_we       = (state == REQ) && wr_q;
   assign ram.ram_addr     = base_q + ADDR_WIDTH'(idx);
   assign ram.ram_data_in  = wdata_q[idx*DATA_WIDTH +: DATA_WIDTH];
   assign busy             = (state == REQ) || (state == GAP);
   assign done             = (state == DONE);

endmodule
